// File: rtl/rgb_led_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rgb_led_pkg
//  Purpose  : Shared types, channel indices and the priority encoder used by
//             the RGB LED arbiter and its PWM channel sub-module.
//  Contents : state_t (IDLE, GRANT), CH_R/CH_G/CH_B, lowest_set_idx()
//  Options  : none (RGB_FADE_EN affects rgb_pwm_channel / rgb_led_arbiter)
//  Revision : 1.0 - initial release
// ============================================================================
package rgb_led_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Channel order inside one requester colour word is {r,g,b}
    localparam int CH_R    = 0;
    localparam int CH_G    = 1;
    localparam int CH_B    = 2;
    localparam int NUM_CH  = 3;

    // Widest request vector the encoder accepts; callers zero-extend.
    localparam int MAX_REQ = 32;

    // Index of the lowest set bit (highest priority). Returns 0 for an
    // all-zero vector; callers qualify with "any request".
    function automatic int lowest_set_idx(input logic [MAX_REQ-1:0] vec);
        int idx;
        idx = 0;
        for (int i = MAX_REQ - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rgb_led_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : rgb_led_arbiter_if
//  Purpose  : Requester-side bus of the RGB LED arbiter.
//  Signals  : req   [NUM_REQ]              level request per requester
//             color [NUM_REQ*3*PWM_BITS]   {r,g,b} per requester
//             gnt   [NUM_REQ]              one-hot registered grant
//             busy                          arbiter/LED activity flag
//  Modports : master (requesters), slave (arbiter)
//  Revision : 1.0 - initial release
// ============================================================================
interface rgb_led_arbiter_if #(
    parameter int NUM_REQ  = 4,
    parameter int PWM_BITS = 8
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*3*PWM_BITS-1:0] color;
    logic [NUM_REQ-1:0]            gnt;
    logic                          busy;

    modport master (output req, output color, input gnt, input busy);
    modport slave  (input req, input color, output gnt, output busy);
endinterface
`default_nettype wire

// File: rtl/rgb_pwm_channel.sv
`default_nettype none
// ============================================================================
//  Module   : rgb_pwm_channel
//  Purpose  : One LED colour channel: target/duty registers, optional fade
//             stepper and the registered PWM comparator.
//  Ports    : clk, rst_n      clock, async active-low reset
//             tick            1-clk tick strobe (RGB_FADE_EN build only)
//             load            latch load_value as the new target
//             load_value      new target duty
//             pwm_cnt         shared free-running PWM counter
//             pwm             active-high PWM, registered
//             duty_zero       current duty is 0
//  Options  : `define RGB_FADE_EN - duty walks one step per tick to target
//  Revision : 1.0 - initial release
// ============================================================================
module rgb_pwm_channel #(
    parameter int PWM_BITS = 8
) (
    input  wire logic                clk,
    input  wire logic                rst_n,
`ifdef RGB_FADE_EN
    input  wire logic                tick,
`endif
    input  wire logic                load,
    input  wire logic [PWM_BITS-1:0] load_value,
    input  wire logic [PWM_BITS-1:0] pwm_cnt,
    output logic                     pwm,
    output logic                     duty_zero
);

    logic [PWM_BITS-1:0] r_duty;
    logic                r_pwm;

`ifdef RGB_FADE_EN
    logic [PWM_BITS-1:0] r_target;
    logic [PWM_BITS-1:0] w_target_eff;

    // A tick on the load edge already steps toward the new target.
    assign w_target_eff = load ? load_value : r_target;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_target <= '0;
            r_duty   <= '0;
        end else begin
            if (load) begin
                r_target <= load_value;
            end
            if (tick) begin
                if (r_duty < w_target_eff) begin
                    r_duty <= r_duty + 1'b1;
                end else if (r_duty > w_target_eff) begin
                    r_duty <= r_duty - 1'b1;
                end
            end
        end
    end
`else
    // Without fading the target and the duty are the same register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_duty <= '0;
        end else if (load) begin
            r_duty <= load_value;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm <= 1'b0;
        end else begin
            r_pwm <= (r_duty > pwm_cnt);
        end
    end

    assign pwm       = r_pwm;
    assign duty_zero = (r_duty == '0);

endmodule
`default_nettype wire

// File: rtl/rgb_led_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rgb_led_arbiter
//  Purpose  : Shares one RGB LED between NUM_REQ requesters. Fixed priority
//             (index 0 highest) with a minimum hold time in ticks; the
//             winner's colour is latched and driven as three PWM outputs.
//  Ports    : clk, rst_n               clock, async active-low reset
//             bus (slave)              req/color in, gnt/busy out
//             pwm_red/green/blue       active-high PWM, registered
//  Options  : `define RGB_FADE_EN - duties fade one step per tick and busy
//             stays high in IDLE until every duty is back at 0
//  Revision : 1.0 - initial release
// ============================================================================
module rgb_led_arbiter
    import rgb_led_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int PWM_BITS   = 8,
    parameter int TICK_DIV   = 12000,
    parameter int HOLD_TICKS = 16
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    rgb_led_arbiter_if.slave   bus,
    output logic               pwm_red,
    output logic               pwm_green,
    output logic               pwm_blue
);

    localparam int TICK_W  = $clog2(TICK_DIV);
    localparam int HOLD_W  = $clog2(HOLD_TICKS + 1);
    localparam int COLOR_W = NUM_CH * PWM_BITS;

    logic [TICK_W-1:0]   r_tick_cnt;
    logic                w_tick;
    logic [PWM_BITS-1:0] r_pwm_cnt;

    state_t              r_state, w_state_next;
    logic [NUM_REQ-1:0]  r_gnt, w_gnt_next, w_win_onehot;
    logic [HOLD_W-1:0]   r_hold_cnt, w_hold_next, w_hold_inc;
    logic                w_load;
    logic [COLOR_W-1:0]  w_load_color, w_win_color;
    logic                w_any_req;
    int                  w_win_idx;
    logic [NUM_CH-1:0]   w_pwm, w_duty_zero;

    // Tick divider and PWM counter run regardless of arbiter state.
    assign w_tick = (r_tick_cnt == TICK_W'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
            r_pwm_cnt  <= '0;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
            r_pwm_cnt  <= r_pwm_cnt + 1'b1;
        end
    end

    // Winner selection: lowest requesting index and its colour word.
    always_comb begin
        w_win_idx    = lowest_set_idx(MAX_REQ'(bus.req));
        w_any_req    = |bus.req;
        w_win_onehot = '0;
        w_win_color  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (i == w_win_idx) begin
                w_win_onehot[i] = 1'b1;
                w_win_color     = bus.color[i*COLOR_W +: COLOR_W];
            end
        end
    end

    assign w_hold_inc = (r_hold_cnt == HOLD_W'(HOLD_TICKS)) ? r_hold_cnt
                                                            : r_hold_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_gnt      <= '0;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_gnt      <= w_gnt_next;
            r_hold_cnt <= w_hold_next;
        end
    end

    // Re-arbitration happens on the tick that brings the hold count to
    // HOLD_TICKS (and on every tick after, since the count saturates). The
    // lowest requesting index either equals the holder (keep, no relatch),
    // or is a different requester of higher or lower priority (switch).
    always_comb begin
        w_state_next = r_state;
        w_gnt_next   = r_gnt;
        w_hold_next  = r_hold_cnt;
        w_load       = 1'b0;
        w_load_color = '0;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_state_next = GRANT;
                    w_gnt_next   = w_win_onehot;
                    w_hold_next  = '0;
                    w_load       = 1'b1;
                    w_load_color = w_win_color;
                end
            end
            GRANT: begin
                if (w_tick) begin
                    w_hold_next = w_hold_inc;
                    if (w_hold_inc == HOLD_W'(HOLD_TICKS)) begin
                        if (!w_any_req) begin
                            w_state_next = IDLE;
                            w_gnt_next   = '0;
                            w_hold_next  = '0;
                            w_load       = 1'b1;
                        end else if (w_win_onehot != r_gnt) begin
                            w_gnt_next   = w_win_onehot;
                            w_hold_next  = '0;
                            w_load       = 1'b1;
                            w_load_color = w_win_color;
                        end
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
                w_gnt_next   = '0;
                w_hold_next  = '0;
            end
        endcase
    end

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            rgb_pwm_channel #(
                .PWM_BITS   (PWM_BITS)
            ) u_ch (
                .clk        (clk),
                .rst_n      (rst_n),
`ifdef RGB_FADE_EN
                .tick       (w_tick),
`endif
                .load       (w_load),
                .load_value (w_load_color[(NUM_CH-1-c)*PWM_BITS +: PWM_BITS]),
                .pwm_cnt    (r_pwm_cnt),
                .pwm        (w_pwm[c]),
                .duty_zero  (w_duty_zero[c])
            );
        end
    endgenerate

    assign pwm_red   = w_pwm[CH_R];
    assign pwm_green = w_pwm[CH_G];
    assign pwm_blue  = w_pwm[CH_B];
    assign bus.gnt   = r_gnt;
    // Without fading, duty is zeroed on the edge that enters IDLE, so this
    // reduces to state != IDLE; with fading it also covers the fade-out.
    assign bus.busy  = (r_state != IDLE) || !(&w_duty_zero);

endmodule
`default_nettype wire

// File: tb/tb_rgb_led_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rgb_led_arbiter
//  Purpose  : Self-checking bench for rgb_led_arbiter with TICK_DIV=4,
//             HOLD_TICKS=2. Expected grants are queued when stimulus is
//             driven and popped when the DUT reaches the expected edge.
//  Options  : `define RGB_FADE_EN adds the fade scenario
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rgb_led_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int PWM_BITS   = 8;
    localparam int TICK_DIV   = 4;
    localparam int HOLD_TICKS = 2;
    localparam int CW         = 3 * PWM_BITS;

    typedef struct {
        int         at;
        logic [3:0] gnt;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic pwm_red, pwm_green, pwm_blue;
    int   cyc;
    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t exp_q[$];

    rgb_led_arbiter_if #(.NUM_REQ(NUM_REQ), .PWM_BITS(PWM_BITS)) bus ();

    rgb_led_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .PWM_BITS   (PWM_BITS),
        .TICK_DIV   (TICK_DIV),
        .HOLD_TICKS (HOLD_TICKS)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .pwm_red    (pwm_red),
        .pwm_green  (pwm_green),
        .pwm_blue   (pwm_blue)
    );

    always #5 clk = ~clk;

    // cyc = number of rising edges since reset release (edge k -> cyc == k)
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc = 0;
        else        cyc = cyc + 1;
    end

    // A tick edge k is one where the divider wraps: k % TICK_DIV == 0.
    function automatic int tick_after(input int k);
        int t;
        t = k + 1;
        while (t % TICK_DIV != 0) t++;
        return t;
    endfunction

    task automatic wait_until(input int target);
        int guard;
        guard = 0;
        while (cyc < target && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc < target) begin
            n_checks++;
            $display("FAIL wait_timeout: cyc=%0d target=%0d", cyc, target);
        end
    endtask

    task automatic set_color(input int idx, input logic [7:0] r, input logic [7:0] g,
                             input logic [7:0] b);
        bus.color[idx*CW +: CW] = {r, g, b};
    endtask

    task automatic count_pwm(output int r, output int g, output int b);
        r = 0; g = 0; b = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            r += int'(pwm_red);
            g += int'(pwm_green);
            b += int'(pwm_blue);
        end
    endtask

    task automatic test_reset();
        n_checks++; if (bus.gnt !== 4'b0000) $display("FAIL rst_gnt: got %b want 0000", bus.gnt); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus.busy); else n_pass++;
        n_checks++; if ({pwm_red, pwm_green, pwm_blue} !== 3'b000)
            $display("FAIL rst_pwm: got %b want 000", {pwm_red, pwm_green, pwm_blue}); else n_pass++;
    endtask

    task automatic test_reset_mid_grant();
        exp_t e;
        set_color(1, 8'hFF, 8'hFF, 8'hFF);
        bus.req = 4'b0010;
        exp_q.push_back('{cyc + 1, 4'b0010});
        e = exp_q.pop_front();
        n_checks++; if (bus.gnt !== 4'b0000) $display("FAIL rmg_pre: got %b want 0000", bus.gnt); else n_pass++;
        wait_until(e.at);
        n_checks++; if (bus.gnt !== e.gnt) $display("FAIL rmg_gnt: got %b want %b", bus.gnt, e.gnt); else n_pass++;
        @(negedge clk);
`ifndef RGB_FADE_EN
        n_checks++; if (pwm_red !== 1'b1) $display("FAIL rmg_pwm_on: got %b want 1", pwm_red); else n_pass++;
`endif
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (bus.gnt !== 4'b0000) $display("FAIL rmg_async_gnt: got %b want 0000", bus.gnt); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL rmg_async_busy: got %b want 0", bus.busy); else n_pass++;
        n_checks++; if ({pwm_red, pwm_green, pwm_blue} !== 3'b000)
            $display("FAIL rmg_async_pwm: got %b want 000", {pwm_red, pwm_green, pwm_blue}); else n_pass++;
        bus.req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        n_checks++; if (bus.gnt !== 4'b0000) $display("FAIL rmg_idle_gnt: got %b want 0000", bus.gnt); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL rmg_idle_busy: got %b want 0", bus.busy); else n_pass++;
    endtask

    task automatic test_single_grant();
        exp_t e;
        int   r, g, b;
        set_color(2, 8'h80, 8'h00, 8'hFF);
        bus.req = 4'b0100;
        exp_q.push_back('{cyc + 1, 4'b0100});
        e = exp_q.pop_front();
        wait_until(e.at);
        n_checks++; if (bus.gnt !== e.gnt) $display("FAIL single_gnt: got %b want %b", bus.gnt, e.gnt); else n_pass++;
        n_checks++; if (bus.busy !== 1'b1) $display("FAIL single_busy: got %b want 1", bus.busy); else n_pass++;
        @(negedge clk);
        count_pwm(r, g, b);
`ifndef RGB_FADE_EN
        n_checks++; if (r != 128) $display("FAIL single_pwm_r: got %0d want 128", r); else n_pass++;
        n_checks++; if (g != 0)   $display("FAIL single_pwm_g: got %0d want 0", g); else n_pass++;
        n_checks++; if (b != 255) $display("FAIL single_pwm_b: got %0d want 255", b); else n_pass++;
`endif
        n_checks++; if (bus.gnt !== 4'b0100) $display("FAIL single_keep: got %b want 0100", bus.gnt); else n_pass++;
        bus.req = '0;
        exp_q.push_back('{tick_after(cyc), 4'b0000});
        e = exp_q.pop_front();
        wait_until(e.at - 1);
        n_checks++; if (bus.gnt !== 4'b0100) $display("FAIL single_pre_idle: got %b want 0100", bus.gnt); else n_pass++;
        @(negedge clk);
        n_checks++; if (bus.gnt !== e.gnt) $display("FAIL single_idle: got %b want %b", bus.gnt, e.gnt); else n_pass++;
`ifndef RGB_FADE_EN
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL single_idle_busy: got %b want 0", bus.busy); else n_pass++;
`endif
    endtask

    task automatic test_preempt();
        exp_t e;
        int   g, t2;
        bus.req = 4'b0100;
        g  = cyc + 1;
        t2 = tick_after(tick_after(g));
        exp_q.push_back('{g, 4'b0100});
        exp_q.push_back('{t2, 4'b0001});
        e = exp_q.pop_front();
        wait_until(e.at);
        n_checks++; if (bus.gnt !== e.gnt) $display("FAIL preempt_gnt: got %b want %b", bus.gnt, e.gnt); else n_pass++;
        bus.req = 4'b0101;
        e = exp_q.pop_front();
        wait_until(e.at - 1);
        n_checks++; if (bus.gnt !== 4'b0100) $display("FAIL preempt_hold: got %b want 0100", bus.gnt); else n_pass++;
        @(negedge clk);
        n_checks++; if (bus.gnt !== e.gnt) $display("FAIL preempt_switch: got %b want %b", bus.gnt, e.gnt); else n_pass++;
        bus.req = '0;
        exp_q.push_back('{tick_after(tick_after(cyc)), 4'b0000});
        e = exp_q.pop_front();
        wait_until(e.at - 1);
        n_checks++; if (bus.gnt !== 4'b0001) $display("FAIL preempt_min_hold: got %b want 0001", bus.gnt); else n_pass++;
        @(negedge clk);
        n_checks++; if (bus.gnt !== e.gnt) $display("FAIL preempt_idle: got %b want %b", bus.gnt, e.gnt); else n_pass++;
    endtask

    task automatic test_holder_drop();
        exp_t e;
        int   g;
        set_color(2, 8'h00, 8'h00, 8'h00);
        bus.req = 4'b0100;
        g = cyc + 1;
        exp_q.push_back('{g, 4'b0100});
        exp_q.push_back('{tick_after(tick_after(g)), 4'b0000});
        e = exp_q.pop_front();
        wait_until(e.at);
        n_checks++; if (bus.gnt !== e.gnt) $display("FAIL drop_gnt: got %b want %b", bus.gnt, e.gnt); else n_pass++;
        bus.req = '0;
        e = exp_q.pop_front();
        wait_until(e.at - 1);
        n_checks++; if (bus.gnt !== 4'b0100) $display("FAIL drop_hold: got %b want 0100", bus.gnt); else n_pass++;
        n_checks++; if (bus.busy !== 1'b1) $display("FAIL drop_hold_busy: got %b want 1", bus.busy); else n_pass++;
        @(negedge clk);
        n_checks++; if (bus.gnt !== e.gnt) $display("FAIL drop_idle: got %b want %b", bus.gnt, e.gnt); else n_pass++;
`ifndef RGB_FADE_EN
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL drop_idle_busy: got %b want 0", bus.busy); else n_pass++;
`endif
    endtask

    task automatic test_handover_low();
        exp_t e;
        int   g;
        bus.req = 4'b1100;
        g = cyc + 1;
        exp_q.push_back('{g, 4'b0100});
        exp_q.push_back('{tick_after(tick_after(g)), 4'b1000});
        e = exp_q.pop_front();
        wait_until(e.at);
        n_checks++; if (bus.gnt !== e.gnt) $display("FAIL handover_gnt: got %b want %b", bus.gnt, e.gnt); else n_pass++;
        bus.req = 4'b1000;
        e = exp_q.pop_front();
        wait_until(e.at - 1);
        n_checks++; if (bus.gnt !== 4'b0100) $display("FAIL handover_hold: got %b want 0100", bus.gnt); else n_pass++;
        @(negedge clk);
        n_checks++; if (bus.gnt !== e.gnt) $display("FAIL handover_switch: got %b want %b", bus.gnt, e.gnt); else n_pass++;
        bus.req = '0;
        exp_q.push_back('{tick_after(tick_after(cyc)), 4'b0000});
        e = exp_q.pop_front();
        wait_until(e.at);
        n_checks++; if (bus.gnt !== e.gnt) $display("FAIL handover_idle: got %b want %b", bus.gnt, e.gnt); else n_pass++;
    endtask

    task automatic test_simultaneous();
        exp_t e;
        int   r, g, b;
        set_color(1, 8'h40, 8'hC0, 8'h01);
        set_color(3, 8'h11, 8'h22, 8'h33);
        bus.req = 4'b1010;
        exp_q.push_back('{cyc + 1, 4'b0010});
        e = exp_q.pop_front();
        wait_until(e.at);
        n_checks++; if (bus.gnt !== e.gnt) $display("FAIL simul_gnt: got %b want %b", bus.gnt, e.gnt); else n_pass++;
        set_color(1, 8'hFF, 8'h00, 8'h00);
        @(negedge clk);
        count_pwm(r, g, b);
`ifndef RGB_FADE_EN
        n_checks++; if (r != 64)  $display("FAIL simul_pwm_r: got %0d want 64", r); else n_pass++;
        n_checks++; if (g != 192) $display("FAIL simul_pwm_g: got %0d want 192", g); else n_pass++;
        n_checks++; if (b != 1)   $display("FAIL simul_pwm_b: got %0d want 1", b); else n_pass++;
`endif
        n_checks++; if (bus.gnt !== 4'b0010) $display("FAIL simul_keep: got %b want 0010", bus.gnt); else n_pass++;
        bus.req = '0;
        exp_q.push_back('{tick_after(cyc), 4'b0000});
        e = exp_q.pop_front();
        wait_until(e.at);
        n_checks++; if (bus.gnt !== e.gnt) $display("FAIL simul_idle: got %b want %b", bus.gnt, e.gnt); else n_pass++;
    endtask

`ifdef RGB_FADE_EN
    task automatic test_fade();
        int g, t, guard;
        int duty_q[$];
        guard = 0;
        while (bus.busy !== 1'b0 && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL fade_settle: got %b want 0", bus.busy); else n_pass++;
        set_color(0, 8'h05, 8'h00, 8'h00);
        while ((cyc + 1) % TICK_DIV == 0) @(negedge clk);
        bus.req = 4'b0001;
        g = cyc + 1;
        for (int k = 1; k <= 5; k++) duty_q.push_back(k);
        t = g;
        while (duty_q.size() > 0) begin
            t = tick_after(t);
            wait_until(t);
            n_checks++; if (u_dut.g_ch[0].u_ch.r_duty !== 8'(duty_q[0]))
                $display("FAIL fade_up: got %0d want %0d", u_dut.g_ch[0].u_ch.r_duty, duty_q[0]); else n_pass++;
            void'(duty_q.pop_front());
        end
        bus.req = '0;
        for (int k = 4; k >= 0; k--) duty_q.push_back(k);
        while (duty_q.size() > 0) begin
            t = tick_after(t);
            wait_until(t - 1);
            n_checks++; if (bus.busy !== 1'b1) $display("FAIL fade_busy_hi: got %b want 1", bus.busy); else n_pass++;
            @(negedge clk);
            n_checks++; if (u_dut.g_ch[0].u_ch.r_duty !== 8'(duty_q[0]))
                $display("FAIL fade_down: got %0d want %0d", u_dut.g_ch[0].u_ch.r_duty, duty_q[0]); else n_pass++;
            void'(duty_q.pop_front());
        end
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL fade_busy_lo: got %b want 0", bus.busy); else n_pass++;
    endtask
`endif

    initial begin
        bus.req   = '0;
        bus.color = '0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        test_reset_mid_grant();
        test_single_grant();
        test_preempt();
        test_holder_drop();
        test_handover_low();
        test_simultaneous();
`ifdef RGB_FADE_EN
        test_fade();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
